// File: rtl/dmem_responder_if.sv
// Request/response bus between the core-side memory controller (master)
// and dmem_responder (slave).
interface dmem_responder_if #(
    parameter int SIZE = 12
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [SIZE-1:0] req_addr;
    logic [31:0]     req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Byte-addressed data memory responder: one request at a time, fixed access latency.
// Define DMEM_WRITE_ACK_EN to make aligned stores return a response as well.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | counting down the latency; access executes when the counter is 0
// RESP   | holding the response until it is accepted
module dmem_responder #(
    parameter int SIZE    = 12,
    parameter int LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    dmem_responder_if.slave bus,
    output logic            busy
);
    localparam int         WORDS    = 2 ** (SIZE - 2);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t          state, state_next;
    logic [3:0]      cnt;
    logic [2:0]      op_q;
    logic [SIZE-1:0] addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic            err_q;
    logic [31:0]     mem [WORDS];

    logic            accept;
    logic            exec;
    logic            is_store;
    logic            misaligned;
    logic            mem_we;
    logic [1:0]      lane;
    logic [31:0]     rd_word;
    logic [31:0]     load_data;
    logic [31:0]     wr_data;
    logic [3:0]      wr_be;

    assign lane     = addr_q[1:0];
    assign rd_word  = mem[addr_q[SIZE-1:2]];
    assign is_store = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);
    assign exec     = (state == ACCESS) && (cnt == 4'd0);
    // rst_n gating drops a store whose commit edge coincides with reset
    assign mem_we   = exec && is_store && !misaligned && rst_n;

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    always_comb begin
        misaligned = 1'b0;
        load_data  = '0;
        wr_data    = wdata_q;
        wr_be      = '0;
        case (op_q)
            OP_LB, OP_LBU: load_data = {24'b0, rd_word[8*lane +: 8]};
            OP_LH, OP_LHU: begin
                misaligned = addr_q[0];
                load_data  = {16'b0, rd_word[16*addr_q[1] +: 16]};
            end
            OP_LW: begin
                misaligned = (lane != 2'b00);
                load_data  = rd_word;
            end
            OP_SB: begin
                wr_data = {4{wdata_q[7:0]}};
                wr_be   = 4'b0001 << lane;
            end
            OP_SH: begin
                misaligned = addr_q[0];
                wr_data    = {2{wdata_q[15:0]}};
                wr_be      = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            OP_SW: begin
                misaligned = (lane != 2'b00);
                wr_be      = 4'b1111;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[addr_q[SIZE-1:2]][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next    = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        busy          = 1'b1;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                busy          = 1'b0;
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    if (misaligned || !is_store) begin
                        state_next = RESP;
                    end else begin
`ifdef DMEM_WRITE_ACK_EN
                        state_next = RESP;
`else
                        state_next = IDLE;
`endif
                    end
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= bus.req_op;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                cnt     <= CNT_LOAD;
            end else if ((state == ACCESS) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            // stores leave load_data at zero, giving the zero rdata of a write ack
            if (exec) begin
                rdata_q <= misaligned ? 32'd0 : load_data;
                err_q   <= misaligned;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: two responders (LATENCY 1 and 3) against a byte-array model.
module tb_dmem_responder;
`ifdef DMEM_WRITE_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif
    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3,
                           LHU = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = '0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_ready = 1'b0;
    logic        busy0, busy1;

    dmem_responder_if #(.SIZE(12)) bi0 ();
    dmem_responder_if #(.SIZE(12)) bi1 ();

    assign bi0.req_valid = req_valid && !sel;
    assign bi1.req_valid = req_valid && sel;
    assign bi0.req_op    = req_op;
    assign bi1.req_op    = req_op;
    assign bi0.req_addr  = req_addr;
    assign bi1.req_addr  = req_addr;
    assign bi0.req_wdata = req_wdata;
    assign bi1.req_wdata = req_wdata;
    assign bi0.rsp_ready = rsp_ready && !sel;
    assign bi1.rsp_ready = rsp_ready && sel;

    dmem_responder #(.SIZE(12), .LATENCY(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bi0.slave), .busy(busy0));
    dmem_responder #(.SIZE(12), .LATENCY(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bi1.slave), .busy(busy1));

    logic        m_req_ready, m_rsp_valid, m_rsp_err, m_busy;
    logic [31:0] m_rsp_rdata;
    assign m_req_ready = sel ? bi1.req_ready : bi0.req_ready;
    assign m_rsp_valid = sel ? bi1.rsp_valid : bi0.rsp_valid;
    assign m_rsp_rdata = sel ? bi1.rsp_rdata : bi0.rsp_rdata;
    assign m_rsp_err   = sel ? bi1.rsp_err   : bi0.rsp_err;
    assign m_busy      = sel ? busy1         : busy0;

    int total = 0;
    int passed = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mdl [2][4096];
    bit          armed = 0, pend = 0, post_rst = 0;
    bit          p_rsp, p_err, p_commit, p_inst;
    int          t0, lat_p;
    logic [2:0]  p_op;
    int          p_a;
    logic [31:0] p_wd, p_rd;
    bit          in_acc, in_rsp, busy_e;

    always @(negedge clk) begin
        if (!armed) begin
            if (!rst_n) armed = 1;
        end else begin
            in_acc = pend && (cyc < t0 + lat_p);
            in_rsp = pend && p_rsp && (cyc >= t0 + lat_p);
            busy_e = in_acc || in_rsp;
            chk("busy", m_busy, busy_e);
            chk("req_ready", m_req_ready, !busy_e);
            chk("rsp_valid", m_rsp_valid, in_rsp);
            if (in_rsp) begin
                chk("rsp_rdata", m_rsp_rdata, p_rd);
                chk("rsp_err", m_rsp_err, p_err);
            end
            if (post_rst) begin
                chk("rst_rdata", m_rsp_rdata, 0);
                chk("rst_err", m_rsp_err, 0);
                post_rst = 0;
            end
            if (!rst_n) begin
                pend = 0;
                post_rst = 1;
            end else begin
                if (in_acc && (cyc + 1 == t0 + lat_p) && p_commit) begin
                    case (p_op)
                        SB: mdl[p_inst][p_a] = p_wd[7:0];
                        SH: begin
                            mdl[p_inst][p_a]   = p_wd[7:0];
                            mdl[p_inst][p_a+1] = p_wd[15:8];
                        end
                        default: for (int k = 0; k < 4; k++) mdl[p_inst][p_a+k] = p_wd[8*k +: 8];
                    endcase
                end
                if (in_rsp && rsp_ready) pend = 0;
                if (!busy_e) begin
                    pend = 0;
                    if (req_valid) begin
                        pend   = 1;
                        t0     = cyc + 1;
                        p_inst = sel;
                        lat_p  = sel ? 3 : 1;
                        p_op   = req_op;
                        p_a    = int'(req_addr);
                        p_wd   = req_wdata;
                        p_err  = ((p_op == LH || p_op == LHU || p_op == SH) && (p_a % 2 != 0)) ||
                                 ((p_op == LW || p_op == SW) && (p_a % 4 != 0));
                        p_commit = (p_op >= SB) && !p_err;
                        p_rsp  = (p_op < SB) || p_err || ACK;
                        p_rd   = 0;
                        if (!p_err) begin
                            case (p_op)
                                LB, LBU: p_rd = {24'b0, mdl[p_inst][p_a]};
                                LH, LHU: p_rd = {16'b0, mdl[p_inst][p_a+1], mdl[p_inst][p_a]};
                                LW:      p_rd = {mdl[p_inst][p_a+3], mdl[p_inst][p_a+2],
                                                 mdl[p_inst][p_a+1], mdl[p_inst][p_a]};
                                default: p_rd = 0;
                            endcase
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic wait_idle();
        bit ok = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
            if (!m_busy) ok = 1;
            else begin @(posedge clk); #1; end
        end
        if (!ok) chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic do_req(input bit inst, input logic [2:0] op, input logic [11:0] addr,
                          input logic [31:0] wd, input int hold, input bit rnd,
                          output logic [31:0] rd, output logic er, output bit got, output int dly);
        int  h = hold;
        int  tacc;
        bit  done = 0;
        rd = 0; er = 0; got = 0; dly = -1;
        wait_idle();
        sel = inst; req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1;
        @(posedge clk); #1;
        tacc = cyc;
        for (int n = 0; n < 200 && !done; n++) begin
            req_valid = 0;
            if (m_rsp_valid) begin
                if (dly < 0) dly = cyc - tacc;
                if (h > 0) begin
                    chk("bp_req_ready", m_req_ready, 0);
                    rsp_ready = 0;
                    req_valid = (h == 3);
                    h--;
                end else begin
                    rsp_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                if (rsp_ready) begin
                    rd = m_rsp_rdata; er = m_rsp_err; got = 1; done = 1;
                end
            end else begin
                rsp_ready = 0;
                if (!m_busy) done = 1;
            end
            @(posedge clk); #1;
        end
        rsp_ready = 0;
        req_valid = 0;
        if (!done) chk("rsp_timeout", 1, 0);
    endtask

    logic [31:0] rd, saved20;
    logic        er;
    bit          got;
    int          dly;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < 64; w++) begin
                logic [31:0] v;
                v = $urandom;
                if (i == 1 && w == 8) saved20 = v;
                do_req(i[0], SW, 12'(w * 4), v, 0, 0, rd, er, got, dly);
            end
        end

        do_req(0, SW, 12'h010, 32'hDEADBEEF, 0, 0, rd, er, got, dly);
        chk("sw_norsp", got, ACK);
        do_req(0, LW, 12'h010, 0, 0, 0, rd, er, got, dly);
        chk("lw_data", rd, 32'hDEADBEEF);
        chk("lw_err", er, 0);
        chk("lw_latency1", dly, 1);
        do_req(0, SB, 12'h012, 32'h00000055, 0, 0, rd, er, got, dly);
        do_req(0, LW, 12'h010, 0, 0, 0, rd, er, got, dly);
        chk("sb_merge", rd, 32'hDE55BEEF);
        do_req(0, LB, 12'h013, 0, 0, 0, rd, er, got, dly);
        chk("lb_data", rd, 32'h000000DE);
        do_req(0, LHU, 12'h012, 0, 0, 0, rd, er, got, dly);
        chk("lhu_data", rd, 32'h0000DE55);
        do_req(0, LH, 12'h011, 0, 0, 0, rd, er, got, dly);
        chk("lh_mis_err", er, 1);
        chk("lh_mis_data", rd, 0);
        do_req(0, SW, 12'h012, 32'h12345678, 0, 0, rd, er, got, dly);
        chk("sw_mis_rsp", got, 1);
        chk("sw_mis_err", er, 1);
        do_req(0, LW, 12'h010, 0, 0, 0, rd, er, got, dly);
        chk("sw_mis_nowrite", rd, 32'hDE55BEEF);
        do_req(0, LW, 12'h010, 0, 5, 0, rd, er, got, dly);
        chk("bp_data", rd, 32'hDE55BEEF);

        // store to 0x020 on the LATENCY=3 unit, killed by reset in its second ACCESS cycle
        wait_idle();
        sel = 1; req_op = SW; req_addr = 12'h020; req_wdata = 32'hA5A5A5A5; req_valid = 1;
        @(posedge clk); #1 req_valid = 0;
        @(posedge clk); #1 rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
        chk("busy_after_rst", m_busy, 0);
        do_req(1, LW, 12'h020, 0, 0, 0, rd, er, got, dly);
        chk("rst_drop_store", rd, saved20);
        chk("lw_latency3", dly, 3);

        do_req(0, SW, 12'h030, 32'hCAFEF00D, 0, 0, rd, er, got, dly);
        chk("wack_rsp", got, ACK);
        if (ACK) begin
            chk("wack_rdata", rd, 0);
            chk("wack_err", er, 0);
        end
        do_req(0, LW, 12'h030, 0, 0, 0, rd, er, got, dly);
        chk("sw_030_readback", rd, 32'hCAFEF00D);

        for (int i = 0; i < 400; i++) begin
            do_req($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 12'($urandom_range(0, 255)),
                   $urandom, 0, 1, rd, er, got, dly);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the CPU load/store path.
- Accepts one request at a time from the core-side memory controller: a 3-bit op, a byte address and store data.
- Performs byte, half or word access on an internal byte-addressed RAM after a programmable latency.
- Returns right-justified, zero-filled read data through a valid/ready response channel. Sign extension stays with the controller.

Parameters:
- SIZE, 12: byte-address width. RAM holds 2^SIZE bytes, organised as 2^(SIZE-2) 32-bit words.
- LATENCY, 1: cycles spent in ACCESS per request. Legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_op  in  3  op code: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW
- req_addr  in  SIZE  byte address
- req_wdata  in  32  store data, right-justified (SB uses [7:0], SH uses [15:0])
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  load data, right-justified, upper bits zero
- rsp_err  out  1  misaligned access flag, qualified by rsp_valid
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rst_n low at a rising edge):
  - State goes to IDLE.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, latency counter=0.
  - RAM contents are not cleared.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at an edge: latch op, addr and wdata; load counter with LATENCY-1; go to ACCESS.
- ACCESS:
  - req_ready=0.
  - Counter decrements each cycle.
  - At the edge where the counter is 0, execute the access and leave ACCESS.
- Access execution:
  - Word index = addr[SIZE-1:2]. Lane = addr[1:0].
  - LB/LBU: rdata = {24'b0, byte[lane]}.
  - LH/LHU: rdata = {16'b0, half[addr[1]]}.
  - LW: rdata = full word.
  - SB: write wdata[7:0] to byte lane addr[1:0] only.
  - SH: write wdata[15:0] to lanes {addr[1],0} and {addr[1],1} only.
  - SW: write all four lanes.
  - Unaddressed lanes are unchanged.
- Alignment:
  - LH/LHU/SH with addr[0]=1 is misaligned.
  - LW/SW with addr[1:0]!=0 is misaligned.
  - Misaligned access: no RAM write; rdata=0, err=1; always go to RESP.
- After execution:
  - Aligned loads: go to RESP, err=0.
  - Aligned stores: see Optional Feature.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held stable until rsp_valid&&rsp_ready at an edge.
  - On that handshake: rsp_valid=0 and return to IDLE.
  - A new request is accepted no earlier than the cycle after return to IDLE. No overlap.
- Latency:
  - Acceptance edge at T0 gives rsp_valid high in the cycle after edge T0+LATENCY.
  - A store commits to RAM at edge T0+LATENCY.
- Read-after-write: a load accepted after a store completes returns the stored data.
- Address bits are only SIZE wide; there is no wrap or overflow handling beyond truncation.
- Reset during ACCESS: an uncommitted store is dropped, the pending response is discarded, and state goes to IDLE.
- Reset during RESP: the response is discarded.
- req_op and req_addr are ignored when req_valid=0 or req_ready=0.

Optional Feature:
- Macro: DMEM_WRITE_ACK_EN.
- Defined: aligned stores also enter RESP with rsp_rdata=0, rsp_err=0, and must be handshaked before IDLE.
- Undefined: aligned stores return from ACCESS directly to IDLE with no response. rsp_valid is never asserted for them. Misaligned stores still respond with err=1.

Test Plan:
- LATENCY=1: SW addr 0x010 data 0xDEADBEEF, then LW 0x010 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid one cycle after the acceptance edge.
- After the above, SB addr 0x012 data 0x55, then LW 0x010 -> 0xDE55BEEF. LB 0x013 -> 0x000000DE. LHU 0x012 -> 0x0000DE55.
- LH addr 0x011 -> rsp_err=1, rsp_rdata=0. SW 0x012 data 0x12345678 -> err=1 and a following LW 0x010 still returns 0xDE55BEEF.
- Backpressure: LW with rsp_ready low for 5 cycles -> rsp_valid and rsp_rdata stable all 5 cycles, req_ready=0, and a req_valid pulse meanwhile is not accepted.
- LATENCY=3: accept SW 0x020 data 0xA5A5A5A5, pull rst_n low on the second ACCESS cycle, then LW 0x020 -> prior RAM contents are returned and busy=0 right after reset.
- Compile with and without DMEM_WRITE_ACK_EN: SW 0x030 -> response with rdata=0, err=0 versus no rsp_valid and busy low after LATENCY+1 cycles.
